pwm_pulse_generator: RTL
========================

Name: pwm_pulse_generator

Overview:
Pulse-determination stage downstream of the square-wave duty generator. It accepts a 7-bit duty value (0..64, where 64 = 100%) through a valid/ready handshake and double-buffers it into a shadow register. At each period boundary it applies the buffered value and produces a glitch-free registered PWM pulse. A one-cycle period_start strobe marks each boundary so upstream generators can pace their updates.

Parameters:
CNT_WIDTH, 6, period counter width; PWM period = 2^CNT_WIDTH count steps (64)
PRESCALE, 1, sysclk cycles per count step (legal range 1..65535)

Ports:
sysclk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  run enable; 0 holds counters and forces pwm_out low
duty_in  input  7  requested duty, 0..64; values above 64 clamp to 64
duty_valid  input  1  duty_in is presented
duty_ready  output  1  shadow register free; transfer occurs when duty_valid & duty_ready
pwm_out  output  1  registered PWM pulse
period_start  output  1  one-cycle strobe on period wrap
active_duty  output  7  duty value currently in force

Behaviour:
- Reset (sync, high): pre_cnt=0, pcnt=0, active_duty=0, pending_valid=0, pwm_out=0, period_start=0, duty_ready=1. Reset mid-period aborts the period immediately; the pending value is discarded.
- Clamp: on acceptance, a duty_in value above 64 is stored as 64. Width-safe compare: pcnt is zero-extended to 7 bits.
- Prescaler: when enable=1, pre_cnt counts 0..PRESCALE-1. tick=1 when pre_cnt==PRESCALE-1. With PRESCALE=1, tick is high every cycle.
- Period counter pcnt: increments on tick and wraps 2^CNT_WIDTH-1 -> 0. wrap = tick & (pcnt==max).
- Handshake: duty_ready = !pending_valid.
  - Accept (valid & ready) with enable=1: pending <= clamped duty_in, pending_valid <= 1.
  - Accept with enable=0: write active_duty directly (bypass); pending_valid stays 0.
- Load: on a wrap cycle with pending_valid=1, active_duty <= pending and pending_valid <= 0. duty_ready returns high on the next cycle. Accept and load never collide because ready is low while pending is held.
- No pending value at wrap: active_duty is unchanged and keeps repeating.
- pwm_out: registered. In cycle t+1 it equals enable & (pcnt < active_duty) evaluated in cycle t.
  - Per period: high for active_duty*PRESCALE cycles, then low for (64-active_duty)*PRESCALE cycles.
  - duty 0 gives constant 0; duty 64 gives constant 1 with no glitch at wrap.
- period_start: registered, high for exactly one cycle, in the cycle after each wrap.
- enable 1->0: pre_cnt and pcnt are cleared to 0, pwm_out is 0 from the next cycle, and period_start stays low.
- enable 0->1: counting starts at pcnt=0 and pwm_out follows from the next cycle. No period_start strobe is issued for this first period.
- Latency: a value accepted while enabled takes effect at the next wrap. Worst case is 64*PRESCALE+1 cycles to pwm_out.
- Simultaneous reset and any other input: reset wins.

Test Plan:
- Reset: hold reset 3 cycles with duty_valid=1 and duty_in=40 -> all outputs at their reset values, duty_ready=1, active_duty stays 0.
- Steady 50%, PRESCALE=1, enable=0, then:
  - accept duty 32 and raise enable -> active_duty=32 immediately.
  - pwm_out repeats 32 high / 32 low; period_start pulses every 64 cycles, one cycle after each pcnt 63->0.
- Extremes:
  - duty 0 -> pwm_out never high over 3 periods.
  - duty 100 -> active_duty=64, pwm_out continuously high across wraps.
- Double-buffer, running at duty 16:
  - at pcnt=10, accept duty 48 -> duty_ready=0 until the wrap.
  - current period keeps 16 high; next period is 48 high.
  - a second valid held during the wait is accepted only after ready rises.
- Prescale: PRESCALE=3, duty 16 -> 48 cycles high, 144 low; period_start spacing is 192 cycles.
- Mid-operation:
  - drop enable at pcnt=20 -> pwm_out=0 next cycle, counters reset; re-enable -> fresh period from pcnt 0.
  - assert reset at pcnt=30 with pending valid -> pending discarded, active_duty=0.

Source files
------------

// File: rtl/pwm_pulse_generator.sv
// PWM pulse stage: accepts a duty value over valid/ready, double-buffers it and
// applies it at each period wrap, producing a registered glitch-free pulse.
module pwm_pulse_generator #(
    parameter int CNT_WIDTH = 6,
    parameter int PRESCALE  = 1
) (
    input  logic                 sysclk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [CNT_WIDTH:0]   duty_in,
    input  logic                 duty_valid,
    output logic                 duty_ready,
    output logic                 pwm_out,
    output logic                 period_start,
    output logic [CNT_WIDTH:0]   active_duty
);

    localparam int                 DUTY_W   = CNT_WIDTH + 1;
    localparam int                 PRE_W    = 16;
    localparam logic [DUTY_W-1:0]  DUTY_MAX = DUTY_W'(1 << CNT_WIDTH);
    localparam logic [PRE_W-1:0]   PRE_LAST = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0]     r_pre_cnt;
    logic [CNT_WIDTH-1:0] r_pcnt;
    logic [DUTY_W-1:0]    r_pending;
    logic                 r_pending_valid;
    logic [DUTY_W-1:0]    r_active_duty;
    logic                 r_pwm;
    logic                 r_period_start;

    logic                 w_tick;
    logic                 w_wrap;
    logic                 w_accept;
    logic [DUTY_W-1:0]    w_duty_clamped;
    logic [DUTY_W-1:0]    w_pcnt_ext;

    assign w_tick         = enable && (r_pre_cnt == PRE_LAST);
    assign w_wrap         = w_tick && (r_pcnt == {CNT_WIDTH{1'b1}});
    assign w_accept       = duty_valid && !r_pending_valid;
    assign w_duty_clamped = (duty_in > DUTY_MAX) ? DUTY_MAX : duty_in;
    assign w_pcnt_ext     = {1'b0, r_pcnt};

    // NOTE: all state below is updated with non-blocking assignments so every
    // register samples the pre-edge values; blocking here would chain updates.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_pre_cnt       <= '0;
            r_pcnt          <= '0;
            r_pending       <= '0;
            r_pending_valid <= 1'b0;
            r_active_duty   <= '0;
            r_pwm           <= 1'b0;
            r_period_start  <= 1'b0;
        end else begin
            if (enable) begin
                r_pre_cnt <= w_tick ? '0 : r_pre_cnt + 16'd1;
                if (w_tick)
                    r_pcnt <= r_pcnt + 1'b1;
            end else begin
                r_pre_cnt <= '0;
                r_pcnt    <= '0;
            end

            r_pwm          <= enable && (w_pcnt_ext < r_active_duty);
            r_period_start <= w_wrap;

            // Accept and load are exclusive: ready is low while a value is pending.
            if (w_accept) begin
                if (enable) begin
                    r_pending       <= w_duty_clamped;
                    r_pending_valid <= 1'b1;
                end else begin
                    r_active_duty   <= w_duty_clamped;
                end
            end else if (w_wrap && r_pending_valid) begin
                r_active_duty   <= r_pending;
                r_pending_valid <= 1'b0;
            end
        end
    end

    assign duty_ready   = !r_pending_valid;
    assign pwm_out      = r_pwm;
    assign period_start = r_period_start;
    assign active_duty  = r_active_duty;

endmodule
